pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter: DATA_W, default 64, width of the result and Treg payloads.
REQ-002 Parameter: DST_W, default 5, width of the integer and FP destination-register fields.
REQ-003 Parameter: CTRL_W, default 17, width of the packed control-flag bus.
REQ-004 Parameter: CNT_W, default 16, width of the stall counter.
REQ-005 Port: clk, input, 1, the single clock; all state updates on posedge clk.
REQ-006 Port: rst, input, 1, synchronous active-high reset.
REQ-007 Port: in_valid, input, 1, the upstream (EXE) stage presents a beat.
REQ-008 Port: in_ready, output, 1, the stage accepts a beat this cycle.
REQ-009 Port: in_result / in_treg, input, DATA_W each, the ALU result and the store data.
REQ-010 Port: in_dst / in_fp_dst, input, DST_W each, the integer and FP destination registers.
REQ-011 Port: in_ctrl, input, CTRL_W, the packed control flags (MemRead, MemWrite, RegWrite, Byte, double, LoHi, ...).
REQ-012 Port: flush, input, 1, discard all held beats.
REQ-013 Port: out_valid, output, 1, the MEM stage has a beat.
REQ-014 Port: out_ready, input, 1, the MEM stage consumes the beat.
REQ-015 Port: out_result, out_treg, out_dst, out_fp_dst, out_ctrl, output, same widths as the inputs, the held payload.
REQ-016 Port: stall_cnt, output, CNT_W, the stall counter; present only under PIPE_STAGE_PERF_EN.

Function
REQ-017 The stage SHALL hold two entries: a main register driving the out_* ports and a skid register.
REQ-018 State SHALL be encoded as EMPTY (neither entry valid), ONE (main valid), or FULL (main and skid valid).
REQ-019 Accept SHALL be in_valid&&in_ready; consume SHALL be out_valid&&out_ready.
REQ-020 in_ready SHALL be a registered signal equal to (state!=FULL), with no combinational path from out_ready.
REQ-021 out_valid SHALL equal (state!=EMPTY).
REQ-022 EMPTY + accept SHALL load main -> ONE; the beat is visible at the outputs one cycle after acceptance.
REQ-023 ONE + accept + consume SHALL load main with the new beat and stay in ONE, sustaining 1 beat/cycle.
REQ-024 ONE + accept without consume SHALL load skid -> FULL.
REQ-025 ONE + consume without accept SHALL go to EMPTY.
REQ-026 FULL + consume SHALL move skid into main -> ONE; no accept is possible in FULL.
REQ-027 Beats SHALL leave in acceptance order; none are dropped or duplicated except by flush.
REQ-028 flush SHALL override all other events: the next state is EMPTY, an accept in the flush cycle is discarded, and in_ready=1 on the next cycle.
REQ-029 Payload registers SHALL load only on their enable; held payload SHALL remain stable while out_valid&&!out_ready.

Reset
REQ-030 rst SHALL set state=EMPTY, out_valid=0, in_ready=1, all payload outputs=0, and stall_cnt=0.
REQ-031 rst SHALL take priority over flush and over the handshakes.
REQ-032 rst asserted mid-transfer SHALL discard held beats with no partial output.

Configuration
REQ-033 With PIPE_STAGE_PERF_EN defined, stall_cnt SHALL increment each cycle that out_valid&&!out_ready.
REQ-034 With PIPE_STAGE_PERF_EN defined, stall_cnt SHALL saturate at all-ones and SHALL be cleared only by rst.
REQ-035 Without PIPE_STAGE_PERF_EN, the stall_cnt port and its logic SHALL be absent, with behaviour otherwise identical.

Structure
REQ-036 The shared package pipe_pkg SHALL hold the stage-state enum (EMPTY/ONE/FULL) and the in_ctrl bit-index constants (CTRL_MEMREAD=0 ... CTRL_DOUBLE=16).
REQ-037 The payload SHALL be packed into a single vector so that one sub-module, pipe_skid_buf, owns the two-entry state and the registers.

Verification
REQ-038 Scenario: rst, then a beat with in_result=64'h1234 and out_ready=1 -> out_valid=1 and out_result=64'h1234 one cycle after acceptance, then EMPTY.
REQ-039 Scenario: 8 back-to-back beats with out_ready=1 -> 8 outputs on 8 consecutive cycles, in order, and in_ready held at 1.
REQ-040 Scenario: out_ready=0 while 3 beats are offered -> 2 accepted, in_ready=0 from the cycle after the 2nd accept, and out_result stable; after out_ready=1, both beats emerge in order.
REQ-041 Scenario: FULL plus flush with in_valid=1 -> out_valid=0 next cycle, in_ready=1, and the flushed and offered beats never appear.
REQ-042 Scenario (PIPE_STAGE_PERF_EN, CNT_W=4): out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt=15 held; flush does not clear it; rst clears it to 0.
REQ-043 Scenario: rst asserted in FULL together with consume -> the next cycle shows out_valid=0, payload=0, and in_ready=1.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline stage registers: stage occupancy state and
// bit positions of the packed control-flag bus.
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } stage_state_e;

   localparam int unsigned CTRL_MEMREAD    = 0;
   localparam int unsigned CTRL_MEMWRITE   = 1;
   localparam int unsigned CTRL_REGWRITE   = 2;
   localparam int unsigned CTRL_BYTE       = 3;
   localparam int unsigned CTRL_HALF       = 4;
   localparam int unsigned CTRL_UNSIGNED   = 5;
   localparam int unsigned CTRL_LOHI       = 6;
   localparam int unsigned CTRL_FPREGWRITE = 7;
   localparam int unsigned CTRL_FPMEMREAD  = 8;
   localparam int unsigned CTRL_FPMEMWRITE = 9;
   localparam int unsigned CTRL_MOVEFP     = 10;
   localparam int unsigned CTRL_JUMPLINK   = 11;
   localparam int unsigned CTRL_BRANCH     = 12;
   localparam int unsigned CTRL_SIGNEXT    = 13;
   localparam int unsigned CTRL_HILOWRITE  = 14;
   localparam int unsigned CTRL_SINGLE     = 15;
   localparam int unsigned CTRL_DOUBLE     = 16;
   localparam int unsigned CTRL_NUM        = 17;

   function automatic logic stage_has_room(stage_state_e s);
      return s != FULL;
   endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry skid buffer (main + skid) for a packed payload vector.
// in_ready comes straight from a flop so out_ready never reaches it combinationally.
module pipe_skid_buf
   import pipe_pkg::*;
#(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   stage_state_e state_q, state_d;
   logic [W-1:0] main_q, skid_q;
   logic         in_ready_q;
   logic         accept, consume;
   logic         main_en, skid_en, main_from_skid;

   assign in_ready  = in_ready_q;
   assign out_valid = (state_q != EMPTY);
   assign out_data  = main_q;

   always_comb begin
      state_d        = state_q;
      main_en        = 1'b0;
      skid_en        = 1'b0;
      main_from_skid = 1'b0;
      accept         = in_valid && in_ready_q;
      consume        = out_valid && out_ready;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept) begin
                  main_en = 1'b1;
                  state_d = ONE;
               end
            end
            ONE: begin
               if (accept && consume) begin
                  main_en = 1'b1;
               end else if (accept) begin
                  skid_en = 1'b1;
                  state_d = FULL;
               end else if (consume) begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
               // in_ready is low here, so only a consume can move the state
               if (consume) begin
                  main_en        = 1'b1;
                  main_from_skid = 1'b1;
                  state_d        = ONE;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= EMPTY;
         in_ready_q <= 1'b1;
         main_q     <= '0;
         skid_q     <= '0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= stage_has_room(state_d);
         if (main_en) begin
            main_q <= main_from_skid ? skid_q : in_data;
         end
         if (skid_en) begin
            skid_q <= in_data;
         end
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// EXE->MEM pipeline stage register with full-throughput skid buffering and flush.
// Define PIPE_STAGE_PERF_EN to add the saturating stall_cnt output.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned DST_W  = 5,
   parameter int unsigned CTRL_W = 17,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_result,
   input  logic [DATA_W-1:0] in_treg,
   input  logic [DST_W-1:0]  in_dst,
   input  logic [DST_W-1:0]  in_fp_dst,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic [DATA_W-1:0] out_treg,
   output logic [DST_W-1:0]  out_dst,
   output logic [DST_W-1:0]  out_fp_dst,
   output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt
`endif
);

   localparam int unsigned PayloadW = CTRL_W + 2 * DST_W + 2 * DATA_W;

   logic [PayloadW-1:0] in_data, out_data;

   assign in_data = {in_ctrl, in_fp_dst, in_dst, in_treg, in_result};
   assign {out_ctrl, out_fp_dst, out_dst, out_treg, out_result} = out_data;

   pipe_skid_buf #(
      .W (PayloadW)
   ) u_skid_buf (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

`ifdef PIPE_STAGE_PERF_EN
   logic [CNT_W-1:0] stall_cnt_q;

   // Only rst clears the counter; flush intentionally leaves it alone
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
      end else if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: accepted beats are queued in order, and a
// negedge monitor checks handshakes, payload and (optionally) the stall counter.
module tb_pipe_stage_reg;

   localparam int unsigned DATA_W = 64;
   localparam int unsigned DST_W  = 5;
   localparam int unsigned CTRL_W = 17;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned PW     = CTRL_W + 2 * DST_W + 2 * DATA_W;
   localparam int          CNT_MAX = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic [DATA_W-1:0] in_result, in_treg, out_result, out_treg;
   logic [DST_W-1:0]  in_dst, in_fp_dst, out_dst, out_fp_dst;
   logic [CTRL_W-1:0] in_ctrl, out_ctrl;
`ifdef PIPE_STAGE_PERF_EN
   logic [CNT_W-1:0]  stall_cnt;
`endif

   logic [PW-1:0] in_pl, out_pl;
   assign in_pl  = {in_ctrl, in_fp_dst, in_dst, in_treg, in_result};
   assign out_pl = {out_ctrl, out_fp_dst, out_dst, out_treg, out_result};

   always #5 clk = ~clk;

   pipe_stage_reg #(
      .DATA_W (DATA_W),
      .DST_W  (DST_W),
      .CTRL_W (CTRL_W),
      .CNT_W  (CNT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_result  (in_result),
      .in_treg    (in_treg),
      .in_dst     (in_dst),
      .in_fp_dst  (in_fp_dst),
      .in_ctrl    (in_ctrl),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_treg   (out_treg),
      .out_dst    (out_dst),
      .out_fp_dst (out_fp_dst),
      .out_ctrl   (out_ctrl)
`ifdef PIPE_STAGE_PERF_EN
      ,
      .stall_cnt  (stall_cnt)
`endif
   );

   int checks = 0;
   int errors = 0;

   // Reference model: beats held by the stage, oldest first
   logic [PW-1:0] q[$];
   bit            mon_en = 1'b0;
   bit            expect_zero = 1'b1;
   int            stall_m = 0;

   task automatic chk_bit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   task automatic chk_vec(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      int sz;
      if (mon_en) begin
         sz = q.size();
         chk_bit("out_valid", out_valid, sz != 0);
         chk_bit("in_ready", in_ready, sz < 2);
         if (sz != 0) chk_vec("payload", out_pl, q[0]);
         else if (expect_zero) chk_vec("reset_payload", out_pl, '0);
`ifdef PIPE_STAGE_PERF_EN
         chk_int("stall_cnt", int'(stall_cnt), stall_m);
`endif
         if (rst) begin
            q.delete();
            expect_zero = 1'b1;
            stall_m = 0;
         end else begin
            if (sz != 0 && !out_ready && stall_m < CNT_MAX) stall_m++;
            if (flush) begin
               q.delete();
            end else begin
               if (sz != 0 && out_ready) void'(q.pop_front());
               if (in_valid && sz < 2) begin
                  q.push_back(in_pl);
                  expect_zero = 1'b0;
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_payload();
      in_result = {$urandom, $urandom};
      in_treg   = {$urandom, $urandom};
      in_dst    = DST_W'($urandom);
      in_fp_dst = DST_W'($urandom);
      in_ctrl   = CTRL_W'($urandom);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_result = '0; in_treg = '0; in_dst = '0; in_fp_dst = '0; in_ctrl = '0;
      step();
      mon_en = 1'b1;
      step();
      rst = 1'b0;

      // Single beat, visible one cycle after acceptance
      in_valid = 1'b1; in_result = 64'h1234; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      chk_bit("single_valid", out_valid, 1'b1);
      chk_vec("single_result", PW'(out_result), PW'(64'h1234));
      repeat (2) step();

      // Back-to-back stream at full rate
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; rand_payload();
         step();
      end
      in_valid = 1'b0;
      repeat (3) step();

      // Backpressure: three offers, two fit
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; rand_payload();
         step();
      end
      in_valid = 1'b0;
      repeat (3) step();
      out_ready = 1'b1;
      repeat (4) step();

      // Flush while full with a beat offered
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; rand_payload();
         step();
      end
      flush = 1'b1; rand_payload();
      step();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (4) step();

      // Reset while full and consuming
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; rand_payload();
         step();
      end
      in_valid = 1'b0; rst = 1'b1; out_ready = 1'b1;
      step();
      rst = 1'b0;
      repeat (2) step();

      // Long stall saturates the counter; flush keeps it, rst clears it
      out_ready = 1'b0; in_valid = 1'b1; rand_payload();
      step();
      in_valid = 1'b0;
      repeat (20) step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      repeat (3) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      repeat (2) step();

      // Randomized traffic with varying backpressure
      for (int i = 0; i < 3000; i++) begin
         int rdy_pct;
         rdy_pct   = (i / 500) % 2 == 0 ? 80 : 30;
         in_valid  = $urandom_range(0, 99) < 60;
         out_ready = $urandom_range(0, 99) < rdy_pct;
         flush     = $urandom_range(0, 99) < 2;
         rst       = $urandom_range(0, 199) < 1;
         rand_payload();
         step();
      end

      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (5) step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
